// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC injection channel between
// NUM_REQ local sources; grant is held until the last flit of a packet is accepted.
module noc_inject_arbiter #(
   parameter int FLIT_WIDTH  = 32,
   parameter int NUM_REQ     = 2,
   parameter int MAX_PKT_LEN = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ*FLIT_WIDTH-1:0] in_flit,
   input  logic [NUM_REQ-1:0]            in_last,
   input  logic [NUM_REQ-1:0]            in_valid,
   output logic [NUM_REQ-1:0]            in_ready,
   output logic [FLIT_WIDTH-1:0]         out_flit,
   output logic                          out_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          len_err,
   input  logic                          len_err_clr
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
   logic [IDX_W-1:0] grant_q, grant_q_next;
   logic [IDX_W-1:0] winner, owner;
   logic [7:0]       cnt, cnt_next;
   logic             len_err_next;
   logic             any_valid, active, xfer;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   // Round-robin scan starting at rr_ptr; first valid requester wins.
   always_comb begin
      int j;
      j         = 0;
      winner    = '0;
      any_valid = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any_valid && in_valid[IDX_W'(j)]) begin
            any_valid = 1'b1;
            winner    = IDX_W'(j);
         end
      end
   end

   // Outputs are a zero-latency mux of the owner, forced to 0 while idle or in reset.
   always_comb begin
      owner     = (state == BUSY) ? grant_q : winner;
      active    = rst_n && ((state == BUSY) || any_valid);
      grant     = '0;
      out_valid = 1'b0;
      out_flit  = '0;
      out_last  = 1'b0;
      if (active) begin
         grant[owner] = 1'b1;
         out_valid    = in_valid[owner];
         out_flit     = in_flit[owner*FLIT_WIDTH +: FLIT_WIDTH];
         out_last     = in_last[owner];
      end
      in_ready = grant & {NUM_REQ{out_ready}};
      xfer     = out_valid && out_ready;
   end

   always_comb begin
      state_next   = state;
      rr_ptr_next  = rr_ptr;
      grant_q_next = grant_q;
      cnt_next     = cnt;
      len_err_next = len_err;
      if (xfer && (cnt == 8'(MAX_PKT_LEN))) begin
         len_err_next = 1'b1;
      end else if (len_err_clr) begin
         len_err_next = 1'b0;
      end
      case (state)
         IDLE: begin
            if (xfer) begin
               if (out_last) begin
                  rr_ptr_next = next_idx(winner);
               end else begin
                  grant_q_next = winner;
                  state_next   = BUSY;
                  cnt_next     = 8'd1;
               end
            end
         end
         BUSY: begin
            if (xfer) begin
               if (out_last) begin
                  state_next  = IDLE;
                  rr_ptr_next = next_idx(grant_q);
                  cnt_next    = 8'd0;
               end else if (cnt != 8'hFF) begin
                  cnt_next = cnt + 8'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         grant_q <= '0;
         cnt     <= '0;
         len_err <= 1'b0;
      end else begin
         state   <= state_next;
         rr_ptr  <= rr_ptr_next;
         grant_q <= grant_q_next;
         cnt     <= cnt_next;
         len_err <= len_err_next;
      end
   end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Bench for noc_inject_arbiter: packet sources drive the DUT and every cycle is
// compared against an integer-level arbitration model.
module tb_noc_inject_arbiter;

   localparam int FW   = 32;
   localparam int NR   = 2;
   localparam int MAXL = 8;
   localparam int OW   = 2*NR + FW + 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR*FW-1:0] in_flit;
   logic [NR-1:0]    in_last, in_valid, in_ready, grant;
   logic [FW-1:0]    out_flit;
   logic             out_last, out_valid, out_ready, len_err, len_err_clr;

   noc_inject_arbiter #(.FLIT_WIDTH(FW), .NUM_REQ(NR), .MAX_PKT_LEN(MAXL)) dut (
      .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .out_flit(out_flit),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .grant(grant), .len_err(len_err), .len_err_clr(len_err_clr)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model state: owner -1 means no packet in progress.
   int  m_owner, m_ptr, m_cnt;
   bit  m_err;
   int  pkt_q[NR][$];
   int  flit_idx[NR];
   int  pkt_id[NR];
   int  vprob[NR];

   logic [OW-1:0] exp_vec;
   logic [NR-1:0] e_ready;
   int            e_owner;
   bit            e_xfer, e_last;

   function automatic logic [OW-1:0] obs();
      return {grant, out_valid, in_ready, out_last, out_flit, len_err};
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
      for (int i = 0; i < NR; i++) begin
         pkt_q[i].delete();
         flit_idx[i] = 0;
         vprob[i]    = 100;
      end
   endtask

   task automatic drive_sources();
      for (int i = 0; i < NR; i++) begin
         if (pkt_q[i].size() > 0) begin
            in_valid[i]          = int'($urandom_range(99)) < vprob[i];
            in_flit[i*FW +: FW]  = {8'(i + 1), 8'(pkt_id[i]), 16'(flit_idx[i])};
            in_last[i]           = (flit_idx[i] == pkt_q[i][0] - 1);
         end else begin
            in_valid[i]          = 1'b0;
            in_flit[i*FW +: FW]  = '0;
            in_last[i]           = 1'b0;
         end
      end
   endtask

   // Computes expected outputs mid-cycle from the sampled inputs and model state.
   task automatic eval_model();
      logic [NR-1:0] g;
      logic [FW-1:0] f;
      bit            v;
      @(negedge clk);
      e_owner = -1;
      if (rst_n) begin
         if (m_owner >= 0) e_owner = m_owner;
         else for (int k = 0; k < NR; k++)
            if (e_owner < 0 && in_valid[(m_ptr + k) % NR]) e_owner = (m_ptr + k) % NR;
      end
      g = '0; f = '0; v = 1'b0; e_last = 1'b0;
      if (e_owner >= 0) begin
         g[e_owner] = 1'b1;
         v      = in_valid[e_owner];
         f      = in_flit[e_owner*FW +: FW];
         e_last = in_last[e_owner];
      end
      e_ready = g & {NR{out_ready}};
      e_xfer  = v && out_ready;
      exp_vec = {g, v, e_ready, e_last, f, m_err};
   endtask

   task automatic advance();
      @(posedge clk);
      if (e_xfer && m_cnt == MAXL) m_err = 1'b1;
      else if (len_err_clr) m_err = 1'b0;
      if (e_xfer) begin
         if (e_last) begin
            m_owner = -1; m_ptr = (e_owner + 1) % NR; m_cnt = 0;
         end else begin
            m_owner = e_owner; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         end
      end
      for (int i = 0; i < NR; i++) begin
         if (e_ready[i] && in_valid[i]) begin
            flit_idx[i]++;
            if (flit_idx[i] == pkt_q[i][0]) begin
               void'(pkt_q[i].pop_front());
               flit_idx[i] = 0;
               pkt_id[i]++;
            end
         end
      end
      #1;
      drive_sources();
   endtask

   task automatic restart();
      rst_n = 1'b0;
      out_ready = 1'b1;
      len_err_clr = 1'b0;
      model_reset();
      drive_sources();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; out_ready = 1'b1; len_err_clr = 1'b0;
      model_reset();
      #2 rst_n = 1'b0;
      pkt_q[0].push_back(2); pkt_q[1].push_back(2);
      drive_sources();
      #3;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests++; if (in_ready !== 2'b00) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 00", in_ready); end
      tests++; if (grant !== 2'b00) begin fails++; $display("[TB] FAIL reset_grant: got %b expected 00", grant); end
      tests++; if (len_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_len_err: got %b expected 0", len_err); end
      tests++; if (out_flit !== '0) begin fails++; $display("[TB] FAIL reset_out_flit: got %h expected 0", out_flit); end
   endtask

   task automatic test_rr_fairness();
      int order[$];
      int busy_cycles = 0;
      restart();
      for (int i = 0; i < NR; i++) begin pkt_q[i].push_back(3); pkt_q[i].push_back(3); end
      drive_sources();
      for (int c = 0; c < 12; c++) begin
         eval_model();
         tests++; if (obs() !== exp_vec) begin fails++; $display("[TB] FAIL rr cycle %0d: got %h expected %h", c, obs(), exp_vec); end
         if (out_valid) busy_cycles++;
         if (out_valid && out_ready && out_last) order.push_back(grant[1] ? 1 : 0);
         advance();
      end
      tests++;
      if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
         fails++; $display("[TB] FAIL rr_order: got %p expected '{0,1,0,1}", order);
      end
      tests++; if (busy_cycles != 12) begin fails++; $display("[TB] FAIL rr_bubbles: got %0d valid cycles expected 12", busy_cycles); end
   endtask

   task automatic test_lock();
      int req0_before = 0;
      bit seen1 = 1'b0;
      restart();
      pkt_q[0].push_back(4);
      drive_sources();
      for (int c = 0; c < 16; c++) begin
         out_ready = (c % 2 == 0);
         eval_model();
         tests++; if (obs() !== exp_vec) begin fails++; $display("[TB] FAIL lock cycle %0d: got %h expected %h", c, obs(), exp_vec); end
         if (out_valid && out_ready) begin
            if (grant[1]) seen1 = 1'b1;
            else if (!seen1) req0_before++;
         end
         if (c == 0) pkt_q[1].push_back(2);
         advance();
      end
      tests++; if (req0_before != 4 || !seen1) begin fails++; $display("[TB] FAIL lock_order: got %0d req0 flits first (req1 seen %0d) expected 4 (1)", req0_before, seen1); end
   endtask

   task automatic test_single_flit();
      int hits = 0;
      restart();
      for (int p = 0; p < 6; p++) pkt_q[1].push_back(1);
      drive_sources();
      for (int c = 0; c < 6; c++) begin
         eval_model();
         tests++; if (obs() !== exp_vec) begin fails++; $display("[TB] FAIL single cycle %0d: got %h expected %h", c, obs(), exp_vec); end
         if (grant == 2'b10 && out_valid && out_last) hits++;
         advance();
      end
      tests++; if (hits != 6) begin fails++; $display("[TB] FAIL single_stream: got %0d granted flits expected 6", hits); end
   endtask

   task automatic test_length();
      restart();
      pkt_q[0].push_back(MAXL);
      pkt_q[0].push_back(MAXL + 1);
      drive_sources();
      for (int c = 0; c < 20; c++) begin
         len_err_clr = (c == 18);
         eval_model();
         tests++; if (obs() !== exp_vec) begin fails++; $display("[TB] FAIL length cycle %0d: got %h expected %h", c, obs(), exp_vec); end
         if (c == 16) begin tests++; if (len_err !== 1'b0) begin fails++; $display("[TB] FAIL len_err_early: got %b expected 0", len_err); end end
         if (c == 17) begin tests++; if (len_err !== 1'b1) begin fails++; $display("[TB] FAIL len_err_set: got %b expected 1", len_err); end end
         if (c == 19) begin tests++; if (len_err !== 1'b0) begin fails++; $display("[TB] FAIL len_err_clr: got %b expected 0", len_err); end end
         advance();
      end
      len_err_clr = 1'b0;
   endtask

   task automatic test_mid_reset();
      restart();
      pkt_q[0].push_back(5);
      pkt_q[1].push_back(3);
      vprob[1] = 0;
      drive_sources();
      for (int c = 0; c < 2; c++) begin
         eval_model();
         tests++; if (obs() !== exp_vec) begin fails++; $display("[TB] FAIL midrst cycle %0d: got %h expected %h", c, obs(), exp_vec); end
         advance();
      end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (grant !== 2'b00 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_async: got grant %b valid %b expected 00 0", grant, out_valid); end
      model_reset();
      drive_sources();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      pkt_q[1].push_back(2);
      drive_sources();
      for (int c = 0; c < 3; c++) begin
         eval_model();
         tests++; if (obs() !== exp_vec) begin fails++; $display("[TB] FAIL midrst_after cycle %0d: got %h expected %h", c, obs(), exp_vec); end
         advance();
      end
   endtask

   task automatic test_random();
      restart();
      for (int i = 0; i < NR; i++) vprob[i] = 75;
      for (int c = 0; c < 1500; c++) begin
         out_ready   = $urandom_range(99) < 70;
         len_err_clr = $urandom_range(99) < 3;
         eval_model();
         tests++; if (obs() !== exp_vec) begin fails++; $display("[TB] FAIL random cycle %0d: got %h expected %h", c, obs(), exp_vec); end
         for (int i = 0; i < NR; i++)
            if (pkt_q[i].size() < 2) pkt_q[i].push_back(int'($urandom_range(1, MAXL + 3)));
         advance();
      end
      len_err_clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      in_flit = '0; in_last = '0; in_valid = '0;
      out_ready = 1'b0; len_err_clr = 1'b0;
      for (int i = 0; i < NR; i++) pkt_id[i] = 0;
      test_reset();
      test_rr_fairness();
      test_lock();
      test_single_flit();
      test_length();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
